// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared definitions for the digit-serial add/subtract unit:
//   - state_t      : controller states (IDLE, RUN)
//   - calc_ndig    : number of digits per operand (WIDTH / DIGIT)
//   - calc_cnt_w   : digit counter width, clog2(NDIG) with a 1-bit minimum
//   - digit_ok     : legality check for a WIDTH/DIGIT pairing
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

  // The digit size must tile the operand exactly, otherwise the last
  // digit would straddle the MSB and the overflow tap would be wrong.
  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if
// Request/result bundle for digit_serial_addsub.
//   start, serial, sub, a, b : request side, driven by the master
//   sum, cout, ovf, busy, done : result side, driven by the unit (slave)
// WIDTH must match the WIDTH of the unit it is connected to.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             serial;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, serial, sub, a, b,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, serial, sub, a, b,
    output sum, cout, ovf, busy, done
  );

endinterface

// File: rtl/addsub_digit.sv
// addsub_digit
// Combinational DIGIT-bit adder slice, shared by the serial and parallel
// paths so both produce identical carry and overflow behaviour.
//   a_d, b_d : digit operands (b_d already inverted for subtract)
//   cin      : carry into the digit
//   s_d      : digit sum
//   cout     : carry out of the digit MSB
//   c_msb    : carry into the digit MSB (XOR with cout gives signed overflow)
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  // The carry into the MSB is recovered from the MSB sum bit itself
  // (s = a ^ b ^ c), which also covers the DIGIT=1 case where it is cin.
  always_comb begin
    full  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin};
    s_d   = full[DIGIT-1:0];
    cout  = full[DIGIT];
    c_msb = full[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
// Add/subtract unit with a single-cycle parallel mode and a digit-serial
// mode that consumes DIGIT bits per clock, LSB digit first.
//   clk  : rising-edge clock
//   nrst : asynchronous active-low reset
//   bus  : digit_serial_addsub_if.slave
//          start/serial/sub/a/b sampled on an edge while busy=0
//          sum/cout/ovf registered, updated only on completion
//          busy high while a serial op is in flight, done one-cycle pulse
// Subtract is a + ~b + 1 so cout (no-borrow) and ovf are right for every b.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 nrst,
  digit_serial_addsub_if.slave bus
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("digit_serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] par_b;
  logic [WIDTH-1:0] par_s;
  logic             par_c;
  logic             par_cmsb;

  logic [DIGIT-1:0] ser_s;
  logic             ser_c;
  logic             ser_cmsb;

  assign par_b = bus.sub ? ~bus.b : bus.b;

  addsub_digit #(.DIGIT(WIDTH)) u_par (
    .a_d   (bus.a),
    .b_d   (par_b),
    .cin   (bus.sub),
    .s_d   (par_s),
    .cout  (par_c),
    .c_msb (par_cmsb)
  );

  addsub_digit #(.DIGIT(DIGIT)) u_ser (
    .a_d   (a_sh[DIGIT-1:0]),
    .b_d   (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .s_d   (ser_s),
    .cout  (ser_c),
    .c_msb (ser_cmsb)
  );

  // Result digits enter at the top, so after NDIG shifts the first
  // (least significant) digit has reached bit 0.
  if (DIGIT == WIDTH) begin : g_res_single
    assign res_next = ser_s;
  end else begin : g_res_shift
    assign res_next = {ser_s, res_sh[WIDTH-1:DIGIT]};
  end

  // Controller: parallel ops complete in IDLE on the start edge; serial ops
  // walk through RUN for NDIG edges. Result outputs are only written on a
  // completion edge so partial serial results never become visible.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.serial) begin
              sum_q  <= par_s;
              cout_q <= par_c;
              ovf_q  <= par_cmsb ^ par_c;
              done_q <= 1'b1;
            end else begin
              a_sh   <= bus.a;
              b_sh   <= par_b;
              carry  <= bus.sub;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          carry  <= ser_c;
          res_sh <= res_next;
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          if (cnt == LAST_CNT) begin
            sum_q  <= res_next;
            cout_q <= ser_c;
            ovf_q  <= ser_cmsb ^ ser_c;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub
// Scoreboard bench for digit_serial_addsub (WIDTH=8, DIGIT=2).
// Accepted requests push their expected result and completion cycle into
// a queue; a monitor on the falling edge pops on done and also checks
// busy and that held results do not move between completions.
module tb_digit_serial_addsub;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int NDIG = W / D;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           edge_no;
  } exp_t;

  logic clk;
  logic nrst;

  digit_serial_addsub_if #(.WIDTH(W)) bus ();

  digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  exp_t exp_q[$];
  exp_t hold;
  int   cyc       = 0;
  int   free_edge = -1;
  int   busy_lo   = 1;
  int   busy_hi   = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t ref_model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r      = ua - ub;
      sr     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub;
      sr     = sa + sb;
      e.cout = (r > (2**W - 1));
    end
    e.sum     = W'(r);
    e.ovf     = (sr > (2**(W-1) - 1)) || (sr < -(2**(W-1)));
    e.edge_no = 0;
    return e;
  endfunction

  // Drive a request so it is sampled on the next rising edge; the model
  // decides acceptance from whether a serial op still occupies that edge.
  task automatic applyStimulus(input bit ser, input bit s, input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.serial = ser;
    bus.sub    = s;
    bus.a      = ia;
    bus.b      = ib;
    @(posedge clk);
    #1;
    if (cyc > free_edge) begin
      e = ref_model(s, ia, ib);
      if (ser) begin
        e.edge_no = cyc + NDIG;
        free_edge = cyc + NDIG;
        busy_lo   = cyc;
        busy_hi   = cyc + NDIG - 1;
      end else begin
        e.edge_no = cyc;
        free_edge = cyc;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.serial = 1'($urandom);
      bus.sub    = 1'($urandom);
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_sum"},  int'(bus.sum),  0);
    checkOutput({tag, "_cout"}, int'(bus.cout), 0);
    checkOutput({tag, "_ovf"},  int'(bus.ovf),  0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold.sum  = '0;
    hold.cout = 1'b0;
    hold.ovf  = 1'b0;
    busy_lo   = 1;
    busy_hi   = 0;
    free_edge = cyc;
  endtask

  // Pulse reset between edges, partway through whatever is running.
  task automatic pulse_reset();
    #2;
    nrst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    #1;
    nrst = 1'b1;
  endtask

  // Monitor: compares on every falling edge while out of reset.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      checkOutput("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, e.edge_no);
          checkOutput("sum",  int'(bus.sum),  int'(e.sum));
          checkOutput("cout", int'(bus.cout), int'(e.cout));
          checkOutput("ovf",  int'(bus.ovf),  int'(e.ovf));
          hold = e;
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].edge_no <= cyc) begin
          e = exp_q.pop_front();
          checkOutput("missing_done", 0, 1);
          hold = e;
        end else begin
          checkOutput("hold_sum",  int'(bus.sum),  int'(hold.sum));
          checkOutput("hold_cout", int'(bus.cout), int'(hold.cout));
          checkOutput("hold_ovf",  int'(bus.ovf),  int'(hold.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst       = 1'b0;
    bus.start  = 1'b0;
    bus.serial = 1'b0;
    bus.sub    = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    nrst = 1'b1;
    model_reset();

    $display("[TB] directed serial and parallel cases");
    applyStimulus(1'b1, 1'b0, 8'h7F, 8'h01);
    idle(NDIG + 1);
    applyStimulus(1'b1, 1'b1, 8'h05, 8'h07);
    idle(NDIG + 1);
    applyStimulus(1'b1, 1'b1, 8'h80, 8'h01);
    idle(NDIG + 1);
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h00);
    idle(NDIG + 1);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'h01);
    idle(2);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h80);
    idle(2);

    $display("[TB] start re-asserted mid-run");
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'h55);
    idle(1);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
    idle(NDIG + 1);

    $display("[TB] back-to-back serial in the done cycle");
    applyStimulus(1'b1, 1'b1, 8'h7F, 8'hFF);
    idle(NDIG);
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h5A);
    idle(NDIG - 1);
    applyStimulus(1'b0, 1'b0, 8'h11, 8'h22);
    idle(NDIG + 2);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34);
    idle(1);
    pulse_reset();
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h02);
    idle(NDIG + 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      idle(int'($urandom_range(0, NDIG + 1)));
    end

    idle(NDIG + 3);
    checkOutput("drain_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
